// File: rtl/st_ordered_demultiplexer_pkg.sv
// Purpose: shared defaults and elaboration helpers for the ordered demultiplexer.
// Ports  : none (package).
package st_ordered_demultiplexer_pkg;

    localparam int unsigned SOD_NB_OUT_DEF = 2;
    localparam int unsigned SOD_DWIDTH_DEF = 250;
    localparam int unsigned SOD_DEPTH_DEF  = 16;

    // True for powers of two that are at least 2.
    function automatic logic is_pow2(input int unsigned v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/st_order_queue.sv
// Purpose: DEPTH x W circular FIFO holding destination orders; first-word-fall-through head,
//          occupancy output and a registered full flag.
// Ports  : clk, rst (async active-low), i_push/i_push_data (write), i_pop (consume head),
//          o_head (current head entry), o_occup (entry count 0..DEPTH), o_full (count == DEPTH).
module st_order_queue
    import st_ordered_demultiplexer_pkg::*;
#(
    parameter int unsigned DEPTH = SOD_DEPTH_DEF,
    parameter int unsigned W     = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [W-1:0]           i_push_data,
    input  logic                   i_pop,
    output logic [W-1:0]           o_head,
    output logic [$clog2(DEPTH):0] o_occup,
    output logic                   o_full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    if (!is_pow2(DEPTH)) begin : g_depth_chk
        $error("st_order_queue: DEPTH must be a power of two >= 2");
    end

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_full;
    logic [CW-1:0] w_count_nxt;
    logic          w_push;
    logic          w_pop;

    // A full queue refuses pushes even when a pop happens in the same cycle.
    assign w_push = i_push & ~r_full;
    assign w_pop  = i_pop & (r_count != '0);

    // Next occupancy; simultaneous push and pop leave it unchanged.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
        end
    end

    // Storage needs no reset; only entries below r_count are ever observed.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_occup = r_count;
    assign o_full  = r_full;

endmodule

// File: rtl/st_ordered_demultiplexer.sv
// Purpose: steers each input beat to the output named by the next entry of the order stream.
// Ports  : clk, rst (async active-low);
//          in_valid/in_ready/in_data           - input beat stream;
//          out_valid/out_ready/out_data [NB_OUT] - registered per-output streams;
//          order_valid/order_ready/order_data  - destination order stream;
//          order_occup                         - queued order count.
module st_ordered_demultiplexer
    import st_ordered_demultiplexer_pkg::*;
#(
    parameter int unsigned NB_OUT = SOD_NB_OUT_DEF,
    parameter int unsigned DWIDTH = SOD_DWIDTH_DEF,
    parameter int unsigned DEPTH  = SOD_DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DWIDTH-1:0]         in_data,
    output logic                      out_valid [NB_OUT],
    input  logic                      out_ready [NB_OUT],
    output logic [DWIDTH-1:0]         out_data  [NB_OUT],
    input  logic                      order_valid,
    output logic                      order_ready,
    input  logic [$clog2(NB_OUT)-1:0] order_data,
    output logic [$clog2(DEPTH):0]    order_occup
);

    localparam int unsigned IDW = $clog2(NB_OUT);

    if (!is_pow2(NB_OUT)) begin : g_nb_out_chk
        $error("st_ordered_demultiplexer: NB_OUT must be a power of two >= 2");
    end

    logic                    r_out_valid [NB_OUT];
    logic [DWIDTH-1:0]       r_out_data  [NB_OUT];
    logic [IDW-1:0]          w_dest;
    logic [$clog2(DEPTH):0]  w_occup;
    logic                    w_full;
    logic                    w_free;
    logic                    w_accept;
    logic                    w_push;

    assign w_push = order_valid & ~w_full;

    st_order_queue #(
        .DEPTH (DEPTH),
        .W     (IDW)
    ) u_order_queue (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (order_data),
        .i_pop       (w_accept),
        .o_head      (w_dest),
        .o_occup     (w_occup),
        .o_full      (w_full)
    );

    // Head destination can take a beat if its register is empty or draining this cycle.
    assign w_free   = ~r_out_valid[w_dest] | out_ready[w_dest];
    assign in_ready = (w_occup != '0) & w_free;
    assign w_accept = in_valid & in_ready;

    // Refill wins over drain so a drained-and-refilled port keeps valid high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NB_OUT); i++) r_out_valid[i] <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NB_OUT); i++) begin
                if (w_accept && (w_dest == IDW'(i))) begin
                    r_out_valid[i] <= 1'b1;
                end else if (out_ready[i]) begin
                    r_out_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Payload registers load only on accept, so data stays stable while a beat is held.
    always_ff @(posedge clk) begin
        if (w_accept) r_out_data[w_dest] <= in_data;
    end

    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign order_ready = ~w_full;
    assign order_occup = w_occup;

endmodule
